// File: rtl/spc7110_bank_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module     : spc7110_bank_fetch_pkg
// Description: Shared region codes, FSM encoding and open-bus value for the
//              SPC7110 bank fetch unit.
// Revision   : 1.0 - initial release
// ============================================================================
package spc7110_bank_fetch_pkg;

    typedef enum logic [1:0] {
        REG_PROM = 2'd0,
        REG_DROM = 2'd1,
        REG_SRAM = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    localparam logic [7:0] OPEN_BUS = 8'hFF;
    localparam int         PADDR_W  = 23;

endpackage
`default_nettype wire

// File: rtl/spc7110_bank_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module     : spc7110_bank_fetch_decode
// Description: Combinational SFC address decode into region and physical
//              ROM/SRAM byte address.
// Revision   : 1.0 - initial release
// ============================================================================
module spc7110_bank_fetch_decode
    import spc7110_bank_fetch_pkg::*;
#(
    parameter logic [22:0] DROM_BASE = 23'h100000,
    parameter logic [22:0] SRAM_BASE = 23'h7E0000,
    parameter logic [22:0] SRAM_MASK = 23'h001FFF
) (
    input  logic [23:0] sfc_addr,
    input  logic        sram_enable,
    input  logic [2:0]  block_dn_select,
    input  logic [2:0]  block_en_select,
    input  logic [2:0]  block_fn_select,
    output region_t     region,
    output logic [22:0] phys_addr
);

    logic [2:0] w_sel;

    always_comb begin
        region    = REG_NONE;
        phys_addr = '0;
        w_sel     = block_dn_select;
        case (sfc_addr[23:20])
            4'hC: begin
                region    = REG_PROM;
                phys_addr = {3'b000, sfc_addr[19:0]};
            end
            4'hD, 4'hE, 4'hF: begin
                if (sfc_addr[23:20] == 4'hE) w_sel = block_en_select;
                if (sfc_addr[23:20] == 4'hF) w_sel = block_fn_select;
                region    = REG_DROM;
                phys_addr = DROM_BASE + {w_sel, sfc_addr[19:0]};
            end
            default: begin
                // bit 22 clear selects banks $00-$3F/$80-$BF; offset $6000-$7FFF
                if (sram_enable && !sfc_addr[22] && sfc_addr[15:13] == 3'b011) begin
                    region    = REG_SRAM;
                    phys_addr = SRAM_BASE + (sfc_addr[22:0] & SRAM_MASK);
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/spc7110_bank_fetch.sv
`default_nettype none
// ============================================================================
// Module     : spc7110_bank_fetch
// Description: SFC-side fetch engine: decode, req/ack memory access with
//              timeout, and a one-entry read cache.
// Revision   : 1.0 - initial release
// ============================================================================
module spc7110_bank_fetch
    import spc7110_bank_fetch_pkg::*;
#(
    parameter logic [22:0] DROM_BASE = 23'h100000,
    parameter logic [22:0] SRAM_BASE = 23'h7E0000,
    parameter logic [22:0] SRAM_MASK = 23'h001FFF,
    parameter logic [7:0]  TIMEOUT   = 8'd64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:0] sfc_addr,
    input  logic        sfc_rd,
    input  logic        sfc_wr,
    input  logic [7:0]  sfc_data_in,
    input  logic        sram_enable,
    input  logic [2:0]  block_dn_select,
    input  logic [2:0]  block_en_select,
    input  logic [2:0]  block_fn_select,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  sfc_data_out,
    output logic        sfc_data_valid,
    output logic        busy,
    output logic        overrun
);

    fetch_state_t r_state, w_state_next;
    region_t      w_region;
    logic [22:0]  w_phys;
    logic [7:0]   r_timer;
    logic         r_cache_valid;
    logic [22:0]  r_cache_addr;
    logic [7:0]   r_cache_data;
    logic [9:0]   r_sel_copy;
    logic         w_sel_changed, w_hit;
    logic         w_go_hit, w_go_unmapped, w_go_fetch, w_go_write;
    logic         w_done_ack, w_done_timeout, w_overrun_set;

    spc7110_bank_fetch_decode #(
        .DROM_BASE(DROM_BASE),
        .SRAM_BASE(SRAM_BASE),
        .SRAM_MASK(SRAM_MASK)
    ) u_decode (
        .sfc_addr       (sfc_addr),
        .sram_enable    (sram_enable),
        .block_dn_select(block_dn_select),
        .block_en_select(block_en_select),
        .block_fn_select(block_fn_select),
        .region         (w_region),
        .phys_addr      (w_phys)
    );

    assign w_sel_changed = {block_dn_select, block_en_select, block_fn_select, sram_enable} != r_sel_copy;
    assign w_hit         = r_cache_valid && !w_sel_changed && (r_cache_addr == w_phys);

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_go_hit       = 1'b0;
        w_go_unmapped  = 1'b0;
        w_go_fetch     = 1'b0;
        w_go_write     = 1'b0;
        w_done_ack     = 1'b0;
        w_done_timeout = 1'b0;
        w_overrun_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sfc_rd) begin
                    w_overrun_set = sfc_wr;
                    if (w_region == REG_NONE) begin
                        w_go_unmapped = 1'b1;
                    end else if (w_hit) begin
                        w_go_hit = 1'b1;
                    end else begin
                        w_go_fetch   = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end else if (sfc_wr && w_region == REG_SRAM) begin
                    w_go_write   = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_overrun_set = sfc_rd | sfc_wr;
                if (mem_ack) begin
                    w_done_ack   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_timer == TIMEOUT - 8'd1) begin
                    w_done_timeout = 1'b1;
                    w_overrun_set  = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            sfc_data_out   <= OPEN_BUS;
            sfc_data_valid <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            r_timer        <= '0;
            r_cache_valid  <= 1'b0;
            r_cache_addr   <= '0;
            r_cache_data   <= '0;
            r_sel_copy     <= '0;
        end else begin
            sfc_data_valid <= 1'b0;
            r_sel_copy     <= {block_dn_select, block_en_select, block_fn_select, sram_enable};
            if (w_overrun_set) overrun <= 1'b1;
            if (w_go_hit) begin
                sfc_data_out   <= r_cache_data;
                sfc_data_valid <= 1'b1;
            end
            if (w_go_unmapped) begin
                sfc_data_out   <= OPEN_BUS;
                sfc_data_valid <= 1'b1;
            end
            if (w_go_fetch || w_go_write) begin
                mem_req  <= 1'b1;
                mem_we   <= w_go_write;
                mem_addr <= w_phys;
                busy     <= 1'b1;
                r_timer  <= '0;
            end
            if (w_go_write) mem_wdata <= sfc_data_in;
            if (r_state == ST_REQ && !w_done_ack && !w_done_timeout) r_timer <= r_timer + 8'd1;
            if (w_done_ack || w_done_timeout) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                busy    <= 1'b0;
            end
            if (w_done_ack && !mem_we) begin
                sfc_data_out   <= mem_rdata;
                sfc_data_valid <= 1'b1;
                r_cache_valid  <= 1'b1;
                r_cache_addr   <= mem_addr;
                r_cache_data   <= mem_rdata;
            end
            if (w_done_ack && mem_we && r_cache_addr == mem_addr) r_cache_valid <= 1'b0;
            if (w_done_timeout && !mem_we) begin
                sfc_data_out   <= OPEN_BUS;
                sfc_data_valid <= 1'b1;
            end
            // a select change makes any cached line stale; this overrides a same-cycle fill
            if (w_sel_changed) r_cache_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spc7110_bank_fetch.sv
`default_nettype none
// ============================================================================
// Module     : tb_spc7110_bank_fetch
// Description: Directed self-checking bench for spc7110_bank_fetch.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_spc7110_bank_fetch;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [23:0] sfc_addr = '0;
    logic        sfc_rd = 1'b0, sfc_wr = 1'b0;
    logic [7:0]  sfc_data_in = '0;
    logic        sram_enable = 1'b0;
    logic [2:0]  block_dn_select = '0, block_en_select = '0, block_fn_select = '0;
    logic        mem_req, mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  sfc_data_out;
    logic        sfc_data_valid, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    spc7110_bank_fetch dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .sfc_addr       (sfc_addr),
        .sfc_rd         (sfc_rd),
        .sfc_wr         (sfc_wr),
        .sfc_data_in    (sfc_data_in),
        .sram_enable    (sram_enable),
        .block_dn_select(block_dn_select),
        .block_en_select(block_en_select),
        .block_fn_select(block_fn_select),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .sfc_data_out   (sfc_data_out),
        .sfc_data_valid (sfc_data_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    typedef struct {
        logic [23:0] addr;
        logic [2:0]  dsel, esel, fsel;
        logic        en;
        logic        mapped;
        logic [22:0] paddr;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; sfc_rd = 1'b0; sfc_wr = 1'b0; mem_ack = 1'b0;
        step(); step();
        RESET = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a);
        sfc_addr = a; sfc_rd = 1'b1;
        step();
        sfc_rd = 1'b0;
    endtask

    task automatic do_ack(input logic [7:0] d);
        mem_ack = 1'b1; mem_rdata = d;
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{24'hC12345, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 23'h012345, 8'h11};
        vecs[1] = '{24'hD12345, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 23'h412345, 8'h22};
        vecs[2] = '{24'hE000FF, 3'd3, 3'd5, 3'd0, 1'b0, 1'b1, 23'h6000FF, 8'h33};
        vecs[3] = '{24'hFFFFFF, 3'd3, 3'd5, 3'd7, 1'b0, 1'b1, 23'h0FFFFF, 8'h44};
        vecs[4] = '{24'h807FFF, 3'd3, 3'd5, 3'd7, 1'b1, 1'b1, 23'h7E1FFF, 8'h55};
        vecs[5] = '{24'h3F6000, 3'd3, 3'd5, 3'd7, 1'b1, 1'b1, 23'h7E0000, 8'h66};
        vecs[6] = '{24'h406000, 3'd3, 3'd5, 3'd7, 1'b1, 1'b0, 23'h000000, 8'h00};
        vecs[7] = '{24'h005FFF, 3'd3, 3'd5, 3'd7, 1'b1, 1'b0, 23'h000000, 8'h00};
        vecs[8] = '{24'h006010, 3'd3, 3'd5, 3'd7, 1'b0, 1'b0, 23'h000000, 8'h00};
        vecs[9] = '{24'hBF8000, 3'd3, 3'd5, 3'd7, 1'b1, 1'b0, 23'h000000, 8'h00};

        do_reset();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_data", sfc_data_out, 8'hFF);
        check("rst_valid", sfc_data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // decode table
        for (int i = 0; i < 10; i++) begin
            block_dn_select = vecs[i].dsel; block_en_select = vecs[i].esel;
            block_fn_select = vecs[i].fsel; sram_enable = vecs[i].en;
            do_read(vecs[i].addr);
            check($sformatf("v%0d_req", i), mem_req, vecs[i].mapped);
            if (vecs[i].mapped) begin
                check($sformatf("v%0d_addr", i), mem_addr, vecs[i].paddr);
                check($sformatf("v%0d_we", i), mem_we, 0);
                check($sformatf("v%0d_busy", i), busy, 1);
                do_ack(vecs[i].rdata);
                check($sformatf("v%0d_done_req", i), mem_req, 0);
            end
            check($sformatf("v%0d_valid", i), sfc_data_valid, 1);
            check($sformatf("v%0d_data", i), sfc_data_out, vecs[i].mapped ? vecs[i].rdata : 8'hFF);
            step();
            check($sformatf("v%0d_pulse", i), sfc_data_valid, 0);
        end
        check("tbl_overrun", overrun, 0);

        // miss, delayed ack, hit, invalidate by select change
        do_reset();
        block_dn_select = 3'd3; block_en_select = 3'd0; block_fn_select = 3'd0; sram_enable = 1'b0;
        step();
        do_read(24'hD12345);
        check("miss_req", mem_req, 1);
        check("miss_addr", mem_addr, 23'h412345);
        for (int k = 0; k < 4; k++) step();
        check("miss_hold_req", mem_req, 1);
        check("miss_hold_valid", sfc_data_valid, 0);
        do_ack(8'hA5);
        check("miss_data", sfc_data_out, 8'hA5);
        check("miss_valid", sfc_data_valid, 1);
        check("miss_busy", busy, 0);
        step();
        do_read(24'hD12345);
        check("hit_req", mem_req, 0);
        check("hit_valid", sfc_data_valid, 1);
        check("hit_data", sfc_data_out, 8'hA5);
        block_dn_select = 3'd4;
        step();
        do_read(24'hD12345);
        check("sel_chg_req", mem_req, 1);
        check("sel_chg_addr", mem_addr, 23'h512345);
        do_ack(8'h5A);
        check("sel_chg_data", sfc_data_out, 8'h5A);

        // SRAM write, then disabled window reads open bus
        sram_enable = 1'b1;
        step();
        sfc_addr = 24'h006010; sfc_data_in = 8'h3C; sfc_wr = 1'b1;
        step();
        sfc_wr = 1'b0;
        check("wr_req", mem_req, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 23'h7E0010);
        check("wr_wdata", mem_wdata, 8'h3C);
        check("wr_valid", sfc_data_valid, 0);
        do_ack(8'h00);
        check("wr_done_req", mem_req, 0);
        check("wr_done_valid", sfc_data_valid, 0);
        sram_enable = 1'b0;
        step();
        do_read(24'h006010);
        check("sram_off_req", mem_req, 0);
        check("sram_off_data", sfc_data_out, 8'hFF);
        check("sram_off_valid", sfc_data_valid, 1);

        // write to a cached SRAM address forces the next read to miss
        sram_enable = 1'b1;
        step();
        do_read(24'h006020);
        do_ack(8'h11);
        step();
        do_read(24'h006020);
        check("sram_hit_req", mem_req, 0);
        check("sram_hit_data", sfc_data_out, 8'h11);
        sfc_addr = 24'h006020; sfc_data_in = 8'h99; sfc_wr = 1'b1;
        step();
        sfc_wr = 1'b0;
        do_ack(8'h00);
        do_read(24'h006020);
        check("wr_inval_req", mem_req, 1);
        do_ack(8'h99);
        check("wr_inval_data", sfc_data_out, 8'h99);
        check("sram_overrun", overrun, 0);

        // timeout
        do_read(24'hF00000);
        cyc = 0;
        while (mem_req && cyc < 100) begin
            step();
            cyc++;
        end
        check("to_cycles", cyc, 64);
        check("to_req", mem_req, 0);
        check("to_valid", sfc_data_valid, 1);
        check("to_data", sfc_data_out, 8'hFF);
        check("to_overrun", overrun, 1);

        // read while busy
        do_reset();
        block_dn_select = 3'd3;
        step();
        do_read(24'hD12345);
        check("busy1_req", mem_req, 1);
        do_read(24'hE00000);
        check("busy_overrun", overrun, 1);
        check("busy_addr", mem_addr, 23'h412345);
        check("busy_busy", busy, 1);
        do_ack(8'h77);
        check("busy_data", sfc_data_out, 8'h77);
        step();
        check("busy_no_reissue", mem_req, 0);

        // simultaneous read and write
        do_reset();
        sram_enable = 1'b1;
        step();
        sfc_addr = 24'h006030; sfc_data_in = 8'hEE; sfc_rd = 1'b1; sfc_wr = 1'b1;
        step();
        sfc_rd = 1'b0; sfc_wr = 1'b0;
        check("rdwr_req", mem_req, 1);
        check("rdwr_we", mem_we, 0);
        check("rdwr_overrun", overrun, 1);
        do_ack(8'h42);
        check("rdwr_data", sfc_data_out, 8'h42);

        // reset mid-fetch, late ack ignored
        do_read(24'hC00001);
        check("rstmid_req_pre", mem_req, 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rstmid_req", mem_req, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_overrun", overrun, 0);
        check("rstmid_data", sfc_data_out, 8'hFF);
        do_ack(8'h24);
        check("late_ack_valid", sfc_data_valid, 0);
        check("late_ack_data", sfc_data_out, 8'hFF);
        check("late_ack_req", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
